// File: rtl/spm_bank_ctrl.sv
// Scratchpad bank controller tiling 512x32 spm_bank_sram macros into a DATA_W x DEPTH bank.
// Byte-enable read-modify-write is built only when SPM_BANK_CTRL_RMW_EN is defined.

module spm_bank_sram (
  input  logic        CLK,
  input  logic        CEN,
  input  logic        WEN,
  input  logic [8:0]  A,
  input  logic [31:0] D,
  input  logic [2:0]  EMA,
  input  logic        RETN,
  output logic [31:0] Q
);
  logic [31:0] r_mem [512];
  logic [31:0] r_q;
  logic        w_ema_unused;

  assign w_ema_unused = ^EMA;
  assign Q = r_q;

  // Q holds its last read value across writes and idle cycles
  always_ff @(posedge CLK) begin
    if (!CEN && RETN) begin
      if (!WEN) r_mem[A] <= D;
      else      r_q      <= r_mem[A];
    end
  end
endmodule

module spm_bank_ctrl #(
  parameter int          DATA_W  = 64,
  parameter int          DEPTH   = 1024,
  parameter logic [2:0]  EMA_VAL = 3'h0,
  localparam int         AW      = $clog2(DEPTH),
  localparam int         BW      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BW-1:0]     req_be,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);
  localparam int NC = DATA_W / 32;
  localparam int NR = DEPTH / 512;
  localparam int RW = (NR > 1) ? $clog2(NR) : 1;

  logic                      w_acc;
  logic                      w_access;
  logic                      w_rd_acc;
  logic                      w_wen_n;
  logic [8:0]                w_a;
  logic [DATA_W-1:0]         w_d;
  logic [RW-1:0]             w_req_row;
  logic [RW-1:0]             w_row;
  logic [NR-1:0]             w_cen_n;
  logic [NR-1:0][DATA_W-1:0] w_q;

  logic                      r_vld_p1;
  logic [RW-1:0]             r_row_p1;
  logic [DATA_W-1:0]         r_rdata_hold;

  assign w_req_row = RW'(req_addr >> 9);
  assign w_acc     = req_valid & req_ready;

`ifdef SPM_BANK_CTRL_RMW_EN
  typedef enum logic {S_IDLE, S_MERGE} state_t;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_latch;
  logic [8:0]        r_a;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_wdata;
  logic [BW-1:0]     r_be;

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] wd,
                                                input logic [DATA_W-1:0] q,
                                                input logic [BW-1:0]     be);
    logic [DATA_W-1:0] res;
    for (int b = 0; b < BW; b++) res[b*8 +: 8] = be[b] ? wd[b*8 +: 8] : q[b*8 +: 8];
    return res;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_a     <= req_addr[8:0];
      r_row   <= w_req_row;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // Empty byte-enable writes are accepted without touching the SRAM
  always_comb begin
    w_state_nxt = r_state;
    w_access    = 1'b0;
    w_rd_acc    = 1'b0;
    w_latch     = 1'b0;
    w_wen_n     = 1'b1;
    w_a         = req_addr[8:0];
    w_d         = req_wdata;
    w_row       = w_req_row;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (!req_wen) begin
            w_access = 1'b1;
            w_rd_acc = 1'b1;
          end else if (&req_be) begin
            w_access = 1'b1;
            w_wen_n  = 1'b0;
          end else if (|req_be) begin
            w_access    = 1'b1;
            w_latch     = 1'b1;
            w_state_nxt = S_MERGE;
          end
        end
      end
      S_MERGE: begin
        w_access    = 1'b1;
        w_wen_n     = 1'b0;
        w_a         = r_a;
        w_row       = r_row;
        w_d         = f_merge(r_wdata, w_q[r_row], r_be);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_MERGE);
`else
  logic w_be_unused;

  assign w_be_unused = ^req_be;
  assign req_ready   = 1'b1;
  assign busy        = 1'b0;

  always_comb begin
    w_access = w_acc;
    w_rd_acc = w_acc & ~req_wen;
    w_wen_n  = ~req_wen;
    w_a      = req_addr[8:0];
    w_d      = req_wdata;
    w_row    = w_req_row;
  end
`endif

  always_comb begin
    w_cen_n = '1;
    if (w_access) w_cen_n[w_row] = 1'b0;
  end

  for (genvar r = 0; r < NR; r++) begin : g_row
    for (genvar c = 0; c < NC; c++) begin : g_col
      spm_bank_sram u_sram (
        .CLK  (clk),
        .CEN  (w_cen_n[r]),
        .WEN  (w_wen_n),
        .A    (w_a),
        .D    (w_d[c*32 +: 32]),
        .EMA  (EMA_VAL),
        .RETN (n_rst),
        .Q    (w_q[r][c*32 +: 32])
      );
    end
  end

  // Stage p1: SRAM output for an accepted read, row remembered from accept cycle
  always_ff @(posedge clk) begin
    if (w_rd_acc) r_row_p1 <= w_req_row;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_vld_p1     <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      r_vld_p1 <= w_rd_acc;
      if (r_vld_p1) r_rdata_hold <= w_q[r_row_p1];
    end
  end

  assign rvalid = r_vld_p1;
  assign rdata  = r_vld_p1 ? w_q[r_row_p1] : r_rdata_hold;
endmodule

// File: tb/tb_spm_bank_ctrl.sv
// Directed bench for spm_bank_ctrl; expectations adapt to SPM_BANK_CTRL_RMW_EN.
module tb_spm_bank_ctrl;
  logic        clk;
  logic        n_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic        rvalid;
  logic [63:0] rdata;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  spm_bank_ctrl #(.DATA_W(64), .DEPTH(1024), .EMA_VAL(3'h0)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic wen, input logic [9:0] addr,
                         input logic [63:0] wd, input logic [7:0] be);
    req_valid = v;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
  endtask

  task automatic idle_req();
    set_req(1'b0, 1'b0, 10'd0, 64'd0, 8'd0);
  endtask

  task automatic do_req(input logic wen, input logic [9:0] addr,
                        input logic [63:0] wd, input logic [7:0] be);
    set_req(1'b1, wen, addr, wd, be);
    tick();
    idle_req();
  endtask

  initial begin
    n_rst = 1'b0;
    idle_req();
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cen", dut.w_cen_n, 2'b11);
    #8 n_rst = 1'b1;
    tick();

    // full write then read of addr 5
    set_req(1'b1, 1'b1, 10'd5, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    #1 chk("wr5_cen", dut.w_cen_n, 2'b10);
    tick();
    idle_req();
    chk("wr5_rvalid", rvalid, 0);
    do_req(1'b0, 10'd5, 64'd0, 8'h00);
    chk("rd5_rvalid", rvalid, 1);
    chk("rd5_rdata", rdata, 64'hDEAD_BEEF_0123_4567);
    tick();
    chk("rd5_hold_rvalid", rvalid, 0);
    chk("rd5_hold_rdata", rdata, 64'hDEAD_BEEF_0123_4567);

    // partial write to addr 5
    do_req(1'b1, 10'd5, 64'hFFFF_FFFF_AAAA_AAAA, 8'h0F);
`ifdef SPM_BANK_CTRL_RMW_EN
    chk("pw_ready_lo", req_ready, 0);
    chk("pw_busy_hi", busy, 1);
    chk("pw_rvalid", rvalid, 0);
    chk("pw_rdata_hold", rdata, 64'hDEAD_BEEF_0123_4567);
    tick();
`endif
    chk("pw_ready_hi", req_ready, 1);
    chk("pw_busy_lo", busy, 0);
    do_req(1'b0, 10'd5, 64'd0, 8'h00);
    chk("pw_rd_rvalid", rvalid, 1);
`ifdef SPM_BANK_CTRL_RMW_EN
    chk("pw_rd_rdata", rdata, 64'hDEAD_BEEF_AAAA_AAAA);
`else
    chk("pw_rd_rdata", rdata, 64'hFFFF_FFFF_AAAA_AAAA);
`endif

    // row boundary: preload then back-to-back reads
    do_req(1'b1, 10'd511, 64'h1111_2222_3333_01FF, 8'hFF);
    do_req(1'b1, 10'd512, 64'h4444_5555_6666_0200, 8'hFF);
    do_req(1'b1, 10'd1023, 64'h7777_8888_9999_03FF, 8'hFF);
    set_req(1'b1, 1'b0, 10'd511, 64'd0, 8'h00);
    #1 chk("b2b511_cen", dut.w_cen_n, 2'b10);
    tick();
    chk("b2b511_rvalid", rvalid, 1);
    chk("b2b511_rdata", rdata, 64'h1111_2222_3333_01FF);
    set_req(1'b1, 1'b0, 10'd512, 64'd0, 8'h00);
    #1 chk("b2b512_cen", dut.w_cen_n, 2'b01);
    tick();
    chk("b2b512_rvalid", rvalid, 1);
    chk("b2b512_rdata", rdata, 64'h4444_5555_6666_0200);
    set_req(1'b1, 1'b0, 10'd1023, 64'd0, 8'h00);
    #1 chk("b2b1023_cen", dut.w_cen_n, 2'b01);
    tick();
    chk("b2b1023_rvalid", rvalid, 1);
    chk("b2b1023_rdata", rdata, 64'h7777_8888_9999_03FF);
    set_req(1'b1, 1'b0, 10'd0, 64'd0, 8'h00);
    #1 chk("b2b0_cen", dut.w_cen_n, 2'b10);
    tick();
    idle_req();
    chk("b2b0_rvalid", rvalid, 1);
    tick();
    chk("b2b_end_rvalid", rvalid, 0);

    // empty byte-enable write to addr 7
    do_req(1'b1, 10'd7, 64'h1, 8'hFF);
    set_req(1'b1, 1'b1, 10'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    #1;
`ifdef SPM_BANK_CTRL_RMW_EN
    chk("be0_cen", dut.w_cen_n, 2'b11);
`else
    chk("be0_cen", dut.w_cen_n, 2'b10);
`endif
    tick();
    idle_req();
    chk("be0_ready", req_ready, 1);
    chk("be0_busy", busy, 0);
    do_req(1'b0, 10'd7, 64'd0, 8'h00);
    chk("be0_rd_rvalid", rvalid, 1);
`ifdef SPM_BANK_CTRL_RMW_EN
    chk("be0_rd_rdata", rdata, 64'h1);
    tick();
    chk("be0_hold1", rdata, 64'h1);
    tick();
    chk("be0_hold2", rdata, 64'h1);
`else
    chk("be0_rd_rdata", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("be0_hold1", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("be0_hold2", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    chk("be0_hold_rvalid", rvalid, 0);

    // reset during the merge cycle of a partial write to addr 9
    do_req(1'b1, 10'd9, 64'h0909_0909_0909_0909, 8'hFF);
    do_req(1'b1, 10'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
`ifdef SPM_BANK_CTRL_RMW_EN
    chk("mrg_busy", busy, 1);
`endif
    n_rst = 1'b0;
    #1;
    chk("mrst_ready", req_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_rvalid", rvalid, 0);
    chk("mrst_rdata", rdata, 0);
    chk("mrst_cen", dut.w_cen_n, 2'b11);
    #2 n_rst = 1'b1;
    tick();
    chk("mrst_post_ready", req_ready, 1);
    do_req(1'b0, 10'd9, 64'd0, 8'h00);
    chk("mrst_rd_rvalid", rvalid, 1);
`ifdef SPM_BANK_CTRL_RMW_EN
    chk("mrst_rd_rdata", rdata, 64'h0909_0909_0909_0909);
`else
    chk("mrst_rd_rdata", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
